// File: rtl/kgp_alu_pkg.sv
// Shared ALU definitions: shift direction codes, iterative-shifter state encoding
// and default operand widths.
package kgp_alu_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/iter_shift_unit_if.sv
// Request/response bundle between the ALU sequencer (master) and the iterative
// shifter (slave).
interface iter_shift_unit_if #(
  parameter int WIDTH = kgp_alu_pkg::WIDTH,
  parameter int SHW   = kgp_alu_pkg::SHW
);

  logic             start_i;
  logic [WIDTH-1:0] in_i;
  logic [SHW-1:0]   s_i;
  logic             dir_i;
  logic             arith_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] out_o;

  modport master (
    output start_i, in_i, s_i, dir_i, arith_i,
    input  busy_o, done_o, out_o
  );

  modport slave (
    input  start_i, in_i, s_i, dir_i, arith_i,
    output busy_o, done_o, out_o
  );

endinterface

// File: rtl/shift_step.sv
// Single-position shift of a word: left, logical right or arithmetic right.
// Purely combinational; arith only matters for right shifts.
module shift_step #(
  parameter int WIDTH = kgp_alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             dir_i,
  input  logic             arith_i,
  output logic [WIDTH-1:0] val_o
);
  import kgp_alu_pkg::*;

  // one-bit shift; the vacated MSB takes the sign only for arithmetic right shifts
  always_comb begin
    val_o = val_i;
    case (dir_i)
      DIR_LEFT:  val_o = {val_i[WIDTH-2:0], 1'b0};
      DIR_RIGHT: val_o = {(arith_i & val_i[WIDTH-1]), val_i[WIDTH-1:1]};
      default:   val_o = val_i;
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: one bit position per clock under a start/busy/done
// handshake. The out register doubles as the working register during a shift.
module iter_shift_unit #(
  parameter int WIDTH = kgp_alu_pkg::WIDTH,
  parameter int SHW   = kgp_alu_pkg::SHW
) (
  input  logic              clk,
  input  logic              rst,
  iter_shift_unit_if.slave  bus
);
  import kgp_alu_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] step_s;
  logic [SHW-1:0]   count_q, count_d;
  logic             dir_q, dir_d;
  logic             arith_q, arith_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .val_i   (out_q),
    .dir_i   (dir_q),
    .arith_i (arith_q),
    .val_o   (step_s)
  );

  // state, working register and handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      count_q <= '0;
      dir_q   <= DIR_LEFT;
      arith_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // next-state logic; DONE accepts a new start just like IDLE for back-to-back issue
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    count_d = count_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start_i) begin
          out_d   = bus.in_i;
          count_d = bus.s_i;
          dir_d   = bus.dir_i;
          arith_d = bus.arith_i;
          state_d = (bus.s_i == '0) ? ST_DONE : ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        out_d   = step_s;
        count_d = count_q - SHW'(1);
        if (count_q == SHW'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.out_o  = out_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Scoreboard bench for iter_shift_unit: expected result and done cycle are queued
// at issue and compared when done pulses.
module tb_iter_shift_unit;

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
    int          s;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   accepted = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;
  logic [31:0] last_res = '0;
  exp_t sb[$];
  exp_t mon_e;

  iter_shift_unit_if bus ();

  iter_shift_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] v, input int sh,
                                            input logic d, input logic a);
    logic signed [31:0] sv;
    sv = v;
    if (d == 1'b0) return v << sh;
    else if (a) return sv >>> sh;
    else return v >> sh;
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (bus.busy_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check_eq("ready_timeout", 64'(bus.busy_o), 64'(1'b0));
  endtask

  task automatic drive(input logic [31:0] v, input int sh, input logic d, input logic a);
    bus.in_i    = v;
    bus.s_i     = sh[4:0];
    bus.dir_i   = d;
    bus.arith_i = a;
    bus.start_i = 1'b1;
  endtask

  task automatic push(input logic [31:0] exp_res, input int sh);
    sb.push_back('{res: exp_res, done_cyc: cyc + 1 + sh, s: sh});
    accepted++;
  endtask

  task automatic issue(input logic [31:0] v, input int sh, input logic d, input logic a,
                       input logic [31:0] exp_res);
    wait_ready();
    drive(v, sh, d, a);
    push(exp_res, sh);
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  // Monitor: compares results, done timing, busy length and out holding in idle
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      last_res = '0;
    end else begin
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o) begin
        if (sb.size() == 0) begin
          check_eq("spurious_done", 64'(bus.done_o), 64'(1'b0));
        end else begin
          mon_e = sb.pop_front();
          check_eq("result", 64'(bus.out_o), 64'(mon_e.res));
          check_eq("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
          check_eq("busy_cycles", 64'(busy_cnt), 64'(mon_e.s));
          check_eq("busy_at_done", 64'(bus.busy_o), 64'(1'b0));
          last_res = mon_e.res;
          done_cnt++;
        end
        busy_cnt = 0;
      end else begin
        if (!bus.busy_o) check_eq("out_hold", 64'(bus.out_o), 64'(last_res));
        if (sb.size() != 0 && cyc > sb[0].done_cyc) begin
          mon_e = sb.pop_front();
          check_eq("done_missing", 64'(bus.done_o), 64'(1'b1));
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time %0t, required completion before it", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    int          sh;
    logic        d;
    logic        a;
    int          t;

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.in_i    = '0;
    bus.s_i     = '0;
    bus.dir_i   = 1'b0;
    bus.arith_i = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_out", 64'(bus.out_o), 64'(32'h0));
    check_eq("reset_busy", 64'(bus.busy_o), 64'(1'b0));
    check_eq("reset_done", 64'(bus.done_o), 64'(1'b0));
    rst = 1'b0;
    @(negedge clk);

    issue(32'h0000_00F0, 4, 1'b0, 1'b0, 32'h0000_0F00);
    issue(32'h8000_0000, 31, 1'b1, 1'b1, 32'hFFFF_FFFF);
    issue(32'h8000_0000, 31, 1'b1, 1'b0, 32'h0000_0001);
    issue(32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    issue(32'h8000_0001, 1, 1'b0, 1'b1, 32'h0000_0002);
    issue(32'hF000_000F, 4, 1'b1, 1'b1, 32'hFF00_0000);
    wait_ready();
    repeat (3) @(negedge clk);

    // start held high through an s=3 op while the operand keeps changing
    wait_ready();
    drive(32'h1234_5678, 3, 1'b1, 1'b0);
    push(32'h0246_8ACF, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive($urandom, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    drive(32'h0000_0001, 2, 1'b0, 1'b0);
    push(32'h0000_0004, 2);
    @(negedge clk);
    bus.start_i = 1'b0;

    // reset in the middle of an s=10 op: discarded, no done pulse
    wait_ready();
    drive(32'hFFFF_0000, 10, 1'b1, 1'b1);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_out", 64'(bus.out_o), 64'(32'h0));
    check_eq("midrst_busy", 64'(bus.busy_o), 64'(1'b0));
    check_eq("midrst_done", 64'(bus.done_o), 64'(1'b0));
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (12) @(negedge clk);
    issue(32'h0000_00F0, 4, 1'b0, 1'b0, 32'h0000_0F00);

    for (int i = 0; i < 1000; i++) begin
      v  = $urandom;
      sh = int'($urandom_range(0, 31));
      d  = 1'($urandom_range(0, 1));
      a  = 1'($urandom_range(0, 1));
      issue(v, sh, d, a, ref_shift(v, sh, d, a));
      if ($urandom_range(0, 3) == 0) begin
        wait_ready();
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end

    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check_eq("queue_empty", 64'(sb.size()), 64'(0));
    check_eq("done_count", 64'(done_cnt), 64'(accepted));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
